// File: rtl/unit_propagator_if.sv
// Queue handshake between the unit propagator (master) and the propagation queue (slave).
// The propagator pops literals from the queue head and pushes implied literals back.
interface unit_propagator_if #(
    parameter int LIT_WIDTH = 6
);
    logic                 q_empty;
    logic                 q_full;
    logic [LIT_WIDTH-1:0] q_dout;
    logic                 q_pop;
    logic                 q_push;
    logic [LIT_WIDTH-1:0] q_din;

    modport master (
        input  q_empty, q_full, q_dout,
        output q_pop, q_push, q_din
    );

    modport slave (
        output q_empty, q_full, q_dout,
        input  q_pop, q_push, q_din
    );
endinterface

// File: rtl/unit_propagator.sv
// Boolean unit propagator: pops a literal, assigns it, then scans every clause once,
// pushing implied unit literals back to the queue or flagging a conflict.
//
// state    | meaning
// IDLE     | waiting for a literal on the queue (blocked once a conflict is flagged)
// CHECK    | compare popped literal against the assignment; assign it if free
// SCAN     | evaluate one clause per cycle, push units, stall while queue is full
// CONFLICT | terminal until reset
module unit_propagator #(
    parameter int LIT_WIDTH   = 6,
    parameter int NUM_CLAUSES = 64,
    localparam int NV  = 2 ** (LIT_WIDTH - 1),
    localparam int CIW = $clog2(NUM_CLAUSES),
    localparam int SW  = LIT_WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    unit_propagator_if.master    io_q,
    input  logic                 i_cl_we,
    input  logic [CIW-1:0]       i_cl_addr,
    input  logic [3*SW-1:0]      i_cl_wdata,
    input  logic [CIW:0]         i_cl_count,
    input  logic [LIT_WIDTH-2:0] i_asg_rd_var,
    output logic                 o_asg_rd_assigned,
    output logic                 o_asg_rd_value,
    output logic                 o_busy,
    output logic                 o_conflict,
    output logic                 o_conflict_src,
    output logic [CIW-1:0]       o_conflict_clause
);

    typedef enum logic [1:0] {IDLE, CHECK, SCAN, CONFLICT} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [3*SW-1:0]      r_clause_mem [NUM_CLAUSES];
    logic [LIT_WIDTH-1:0] r_cur_lit;
    logic [NV-1:0]        r_assigned;
    logic [NV-1:0]        r_value;
    logic [CIW:0]         r_count;
    logic [CIW-1:0]       r_idx;
    logic                 r_conflict;
    logic                 r_conflict_src;
    logic [CIW-1:0]       r_conflict_clause;

    logic [LIT_WIDTH-2:0] w_cur_var;
    logic [3*SW-1:0]      w_cl;
    logic [SW-1:0]        w_slot;
    logic [LIT_WIDTH-2:0] w_var;
    logic                 w_any_true;
    logic [1:0]           w_n_valid;
    logic [1:0]           w_n_unasg;
    logic [LIT_WIDTH-1:0] w_unit_lit;
    logic                 w_all_false;
    logic                 w_unit;
    logic                 w_last;

    logic                 w_pop;
    logic                 w_push;
    logic [LIT_WIDTH-1:0] w_din;
    logic                 w_assign;
    logic                 w_adv;
    logic                 w_dconf;
    logic                 w_cconf;

    assign w_cur_var = r_cur_lit[LIT_WIDTH-1:1];
    assign w_last    = ({1'b0, r_idx} == (r_count - 1'b1));

    // Clause evaluation against the assignment as it stands at the start of this scan.
    always_comb begin
        w_cl       = r_clause_mem[r_idx];
        w_slot     = '0;
        w_var      = '0;
        w_any_true = 1'b0;
        w_n_valid  = '0;
        w_n_unasg  = '0;
        w_unit_lit = '0;
        for (int s = 0; s < 3; s++) begin
            w_slot = w_cl[s*SW +: SW];
            if (w_slot[SW-1]) begin
                w_var     = w_slot[LIT_WIDTH-1:1];
                w_n_valid = w_n_valid + 2'd1;
                if (r_assigned[w_var]) begin
                    if (r_value[w_var] != w_slot[0]) w_any_true = 1'b1;
                end else begin
                    w_n_unasg  = w_n_unasg + 2'd1;
                    w_unit_lit = w_slot[LIT_WIDTH-1:0];
                end
            end
        end
    end

    assign w_all_false = (w_n_valid != 2'd0) && !w_any_true && (w_n_unasg == 2'd0);
    assign w_unit      = !w_any_true && (w_n_unasg == 2'd1);

    always_comb begin
        w_next   = r_state;
        w_pop    = 1'b0;
        w_push   = 1'b0;
        w_din    = '0;
        w_assign = 1'b0;
        w_adv    = 1'b0;
        w_dconf  = 1'b0;
        w_cconf  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!io_q.q_empty && !r_conflict) begin
                    w_pop  = 1'b1;
                    w_next = CHECK;
                end
            end
            CHECK: begin
                if (r_assigned[w_cur_var]) begin
                    if (r_value[w_cur_var] != r_cur_lit[0]) begin
                        w_next = IDLE;
                    end else begin
                        w_dconf = 1'b1;
                        w_next  = CONFLICT;
                    end
                end else begin
                    w_assign = 1'b1;
                    w_next   = (i_cl_count == '0) ? IDLE : SCAN;
                end
            end
            SCAN: begin
                if (w_all_false) begin
                    w_cconf = 1'b1;
                    w_next  = CONFLICT;
                end else if (!(w_unit && io_q.q_full)) begin
                    if (w_unit) begin
                        w_push = 1'b1;
                        w_din  = w_unit_lit;
                    end
                    w_adv = 1'b1;
                    if (w_last) w_next = IDLE;
                end
            end
            CONFLICT: begin
                w_next = CONFLICT;
            end
            default: w_next = IDLE;
        endcase
    end

    // Strobes are masked during reset so an in-flight scan is cut off in the same cycle.
    assign io_q.q_pop  = w_pop & ~rst;
    assign io_q.q_push = w_push & ~rst;
    assign io_q.q_din  = rst ? '0 : w_din;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= IDLE;
            r_cur_lit         <= '0;
            r_assigned        <= '0;
            r_value           <= '0;
            r_count           <= '0;
            r_idx             <= '0;
            r_conflict        <= 1'b0;
            r_conflict_src    <= 1'b0;
            r_conflict_clause <= '0;
        end else begin
            r_state <= w_next;
            if (w_pop) r_cur_lit <= io_q.q_dout;
            if (w_assign) begin
                r_assigned[w_cur_var] <= 1'b1;
                r_value[w_cur_var]    <= ~r_cur_lit[0];
                r_count               <= i_cl_count;
                r_idx                 <= '0;
            end
            if (w_adv) r_idx <= r_idx + 1'b1;
            if (w_dconf) begin
                r_conflict     <= 1'b1;
                r_conflict_src <= 1'b1;
            end
            if (w_cconf) begin
                r_conflict        <= 1'b1;
                r_conflict_src    <= 1'b0;
                r_conflict_clause <= r_idx;
            end
        end
    end

    // Clause memory is not reset; it survives a reset of the propagation state.
    always_ff @(posedge clk) begin
        if (i_cl_we && (r_state == IDLE)) r_clause_mem[i_cl_addr] <= i_cl_wdata;
    end

    assign o_asg_rd_assigned = r_assigned[i_asg_rd_var];
    assign o_asg_rd_value    = r_value[i_asg_rd_var];
    assign o_busy            = (r_state != IDLE);
    assign o_conflict        = r_conflict;
    assign o_conflict_src    = r_conflict_src;
    assign o_conflict_clause = r_conflict_clause;

endmodule

// File: tb/tb_unit_propagator.sv
// Bench for unit_propagator: directed scenarios followed by randomized clause sets
// checked against a transaction-level propagation model.
module tb_unit_propagator;

    localparam int LW  = 6;
    localparam int NC  = 64;
    localparam int CIW = 6;
    localparam int NVT = 32;

    logic           clk;
    logic           rst;
    logic           cl_we;
    logic [CIW-1:0] cl_addr;
    logic [20:0]    cl_wdata;
    logic [CIW:0]   cl_count;
    logic [LW-2:0]  asg_rd_var;
    logic           asg_rd_assigned;
    logic           asg_rd_value;
    logic           busy;
    logic           conflict;
    logic           conflict_src;
    logic [CIW-1:0] conflict_clause;

    unit_propagator_if #(.LIT_WIDTH(LW)) qif ();

    unit_propagator #(.LIT_WIDTH(LW), .NUM_CLAUSES(NC)) dut (
        .clk               (clk),
        .rst               (rst),
        .io_q              (qif),
        .i_cl_we           (cl_we),
        .i_cl_addr         (cl_addr),
        .i_cl_wdata        (cl_wdata),
        .i_cl_count        (cl_count),
        .i_asg_rd_var      (asg_rd_var),
        .o_asg_rd_assigned (asg_rd_assigned),
        .o_asg_rd_value    (asg_rd_value),
        .o_busy            (busy),
        .o_conflict        (conflict),
        .o_conflict_src    (conflict_src),
        .o_conflict_clause (conflict_clause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit          m_asg [NVT];
    bit          m_val [NVT];
    bit          mvalid [NC][3];
    logic [5:0]  mlit [NC][3];
    int          mcount;
    bit          mconf;
    bit          msrc;
    int          mclause;
    logic [5:0]  exp_q [$];
    logic [5:0]  tbq [$];
    logic [20:0] wtmp;
    int          acnt;
    bit          done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        qif.q_empty  = 1'b1;
        qif.q_full   = 1'b0;
        qif.q_dout   = '0;
        cl_we        = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic write_clause(input logic [CIW-1:0] a, input logic [20:0] d);
        cl_we    = 1'b1;
        cl_addr  = a;
        cl_wdata = d;
        tick();
        cl_we = 1'b0;
    endtask

    // Offer a literal until it is popped; returns during the CHECK cycle.
    task automatic pop_lit(input logic [5:0] lit);
        bit got;
        got = 1'b0;
        qif.q_empty = 1'b0;
        qif.q_dout  = lit;
        for (int i = 0; i < 50 && !got; i++) begin
            #1;
            if (qif.q_pop) got = 1'b1;
            tick();
        end
        qif.q_empty = 1'b1;
        chk("pop_seen", got, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (!busy) ok = 1'b1;
            else tick();
        end
        chk("idle_timeout", ok, 1);
    endtask

    function automatic logic [20:0] mk3(input bit v0, input logic [5:0] l0,
                                        input bit v1, input logic [5:0] l1,
                                        input bit v2, input logic [5:0] l2);
        return {v2, l2, v1, l1, v0, l0};
    endfunction

    // Transaction-level effect of popping one literal: direct clash, or assign then
    // walk clauses in order collecting implied literals until a falsified clause.
    function automatic void model_pop(input logic [5:0] lit);
        int v;
        int nvalid;
        int nun;
        bit tru;
        logic [5:0] ul;
        logic [5:0] lv;
        v = int'(lit[5:1]);
        if (m_asg[v]) begin
            if (m_val[v] == lit[0]) begin
                mconf = 1'b1;
                msrc  = 1'b1;
            end
        end else begin
            m_asg[v] = 1'b1;
            m_val[v] = ~lit[0];
            for (int c = 0; c < mcount; c++) begin
                nvalid = 0;
                nun    = 0;
                tru    = 1'b0;
                ul     = '0;
                for (int k = 0; k < 3; k++) begin
                    if (mvalid[c][k]) begin
                        lv = mlit[c][k];
                        nvalid++;
                        if (!m_asg[int'(lv[5:1])]) begin
                            nun++;
                            ul = lv;
                        end else if (m_val[int'(lv[5:1])] != lv[0]) begin
                            tru = 1'b1;
                        end
                    end
                end
                if (!tru && nvalid != 0) begin
                    if (nun == 1) exp_q.push_back(ul);
                    else if (nun == 0) begin
                        mconf   = 1'b1;
                        msrc    = 1'b0;
                        mclause = c;
                        break;
                    end
                end
            end
        end
    endfunction

    initial begin
        rst        = 1'b1;
        cl_we      = 1'b0;
        cl_addr    = '0;
        cl_wdata   = '0;
        cl_count   = '0;
        asg_rd_var = '0;
        qif.q_empty = 1'b1;
        qif.q_full  = 1'b0;
        qif.q_dout  = '0;

        // reset state, strobes masked while rst is high
        tick();
        qif.q_empty = 1'b0;
        qif.q_dout  = 6'd2;
        #1;
        chk("rst_pop", qif.q_pop, 0);
        chk("rst_busy", busy, 0);
        chk("rst_conflict", conflict, 0);
        qif.q_empty = 1'b1;
        do_reset();

        // unit implication with exact latency
        write_clause(0, mk3(1, 6'd3, 1, 6'd4, 0, 6'd0));
        cl_count    = 7'd1;
        qif.q_empty = 1'b0;
        qif.q_dout  = 6'd2;
        #1;
        chk("unit_pop_t", qif.q_pop, 1);
        chk("unit_busy_t", busy, 0);
        tick();
        qif.q_empty = 1'b1;
        #1;
        chk("unit_busy_t1", busy, 1);
        chk("unit_push_t1", qif.q_push, 0);
        chk("unit_pop_t1", qif.q_pop, 0);
        tick();
        #1;
        chk("unit_push_t2", qif.q_push, 1);
        chk("unit_din_t2", qif.q_din, 4);
        chk("unit_pop_t2", qif.q_pop, 0);
        tick();
        #1;
        chk("unit_busy_t3", busy, 0);
        chk("unit_push_t3", qif.q_push, 0);
        asg_rd_var = 5'd1;
        #1;
        chk("unit_asg", asg_rd_assigned, 1);
        chk("unit_val", asg_rd_value, 1);

        // reset mid-scan
        do_reset();
        pop_lit(6'd2);
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_push", qif.q_push, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_push2", qif.q_push, 0);
        chk("midrst_conflict", conflict, 0);
        acnt = 0;
        for (int v = 0; v < NVT; v++) begin
            asg_rd_var = 5'(v);
            #1;
            if (asg_rd_assigned) acnt++;
        end
        chk("midrst_asg_cnt", acnt, 0);

        // redundant literal: CHECK then straight back to IDLE
        pop_lit(6'd2);
        wait_idle();
        pop_lit(6'd2);
        #1;
        chk("redund_busy_chk", busy, 1);
        chk("redund_push_chk", qif.q_push, 0);
        tick();
        #1;
        chk("redund_busy_idle", busy, 0);
        chk("redund_push_idle", qif.q_push, 0);

        // back-pressure; a clause write attempted while busy must be dropped
        do_reset();
        pop_lit(6'd2);
        tick();
        qif.q_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                cl_we    = 1'b1;
                cl_addr  = '0;
                cl_wdata = mk3(1, 6'd3, 0, 6'd0, 0, 6'd0);
            end else begin
                cl_we = 1'b0;
            end
            #1;
            chk("bp_push_stall", qif.q_push, 0);
            chk("bp_busy_stall", busy, 1);
            tick();
        end
        cl_we      = 1'b0;
        qif.q_full = 1'b0;
        #1;
        chk("bp_push_release", qif.q_push, 1);
        chk("bp_din_release", qif.q_din, 4);
        tick();
        #1;
        chk("bp_push_once", qif.q_push, 0);
        chk("bp_idle", busy, 0);
        pop_lit(6'd6);
        tick();
        #1;
        chk("we_busy_ignored_push", qif.q_push, 1);
        chk("we_busy_ignored_din", qif.q_din, 4);
        chk("we_busy_ignored_conf", conflict, 0);
        wait_idle();

        // direct clash, then no further pops
        do_reset();
        cl_count = 7'd0;
        pop_lit(6'd2);
        pop_lit(6'd3);
        tick();
        qif.q_empty = 1'b0;
        qif.q_dout  = 6'd6;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("clash_no_pop", qif.q_pop, 0);
            tick();
        end
        qif.q_empty = 1'b1;
        chk("clash_conflict", conflict, 1);
        chk("clash_src", conflict_src, 1);
        chk("clash_busy", busy, 1);

        // clause conflict
        do_reset();
        write_clause(0, mk3(1, 6'd3, 1, 6'd5, 0, 6'd0));
        cl_count = 7'd1;
        pop_lit(6'd4);
        tick();
        #1;
        chk("cconf_push", qif.q_push, 1);
        chk("cconf_din", qif.q_din, 3);
        wait_idle();
        pop_lit(6'd2);
        tick();
        #1;
        chk("cconf_no_push", qif.q_push, 0);
        tick();
        #1;
        chk("cconf_conflict", conflict, 1);
        chk("cconf_src", conflict_src, 0);
        chk("cconf_clause", conflict_clause, 0);

        // randomized clause sets with a closed-loop queue
        for (int r = 0; r < 10; r++) begin
            do_reset();
            mcount = $urandom_range(3, 12);
            for (int c = 0; c < mcount; c++) begin
                wtmp = '0;
                for (int k = 0; k < 3; k++) begin
                    mvalid[c][k] = ($urandom_range(0, 4) != 0);
                    mlit[c][k]   = 6'($urandom_range(0, 15));
                    wtmp[k*7 +: 7] = {mvalid[c][k], mlit[c][k]};
                end
                write_clause(CIW'(c), wtmp);
            end
            cl_count = 7'(mcount);
            for (int v = 0; v < NVT; v++) begin
                m_asg[v] = 1'b0;
                m_val[v] = 1'b0;
            end
            mconf   = 1'b0;
            msrc    = 1'b0;
            mclause = 0;
            exp_q.delete();
            tbq.delete();
            for (int i = 0; i < $urandom_range(1, 3); i++) tbq.push_back(6'($urandom_range(0, 15)));
            done = 1'b0;
            for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
                qif.q_empty = (tbq.size() == 0);
                qif.q_dout  = (tbq.size() != 0) ? tbq[0] : 6'd0;
                qif.q_full  = (tbq.size() >= 8) || ($urandom_range(0, 3) == 0);
                #1;
                chk("pop_push_excl", qif.q_pop & qif.q_push, 0);
                if (qif.q_pop) begin
                    chk("pop_after_conflict", mconf, 0);
                    chk("pushes_drained", exp_q.size(), 0);
                    chk("pop_nonempty", tbq.size() != 0, 1);
                    if (tbq.size() != 0) begin
                        model_pop(tbq[0]);
                        void'(tbq.pop_front());
                    end
                end
                if (qif.q_push) begin
                    chk("push_not_full", qif.q_full, 0);
                    chk("push_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) chk("push_lit", qif.q_din, exp_q.pop_front());
                    tbq.push_back(qif.q_din);
                end
                tick();
                done = conflict || (tbq.size() == 0 && !busy);
            end
            chk("rand_timeout", done, 1);
            chk("rand_conflict", conflict, mconf);
            if (mconf) begin
                chk("rand_src", conflict_src, msrc);
                if (!msrc) chk("rand_clause", conflict_clause, mclause);
            end
            chk("rand_left", exp_q.size(), 0);
            for (int v = 0; v < NVT; v++) begin
                asg_rd_var = 5'(v);
                #1;
                chk("rand_asg", asg_rd_assigned, m_asg[v]);
                if (m_asg[v]) chk("rand_val", asg_rd_value, m_val[v]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
